cfu_bpu: RTL and testbench

CFU_BPU -- requirements
Module: cfu_bpu

---
 rtl/cfu_pkg.sv | 37 +++
 rtl/cfu_cmp.sv | 28 ++
 rtl/cfu_bpu.sv | 134 +++++++++++++
 tb/tb_cfu_bpu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_pkg.sv
// Shared types and constants for the control-flow unit and branch predictor.
package cfu_pkg;

  typedef enum logic [3:0] {
    CfuNone = 4'd0,
    CfuBeq  = 4'd1,
    CfuBne  = 4'd2,
    CfuBlt  = 4'd3,
    CfuBge  = 4'd4,
    CfuBltu = 4'd5,
    CfuBgeu = 4'd6,
    CfuJal  = 4'd7,
    CfuJalr = 4'd8
  } cfuop_t;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic is_cond_br(cfuop_t op);
    return (op >= CfuBeq) && (op <= CfuBgeu);
  endfunction

  function automatic logic is_cfi(cfuop_t op);
    return (op >= CfuBeq) && (op <= CfuJalr);
  endfunction

  function automatic logic [1:0] sat_inc(logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/cfu_cmp.sv
// Branch/jump outcome resolution from operation and compare operands.
module cfu_cmp
  import cfu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  cfuop_t                cfuop,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  output logic                  br_taken
);

  always_comb begin
    br_taken = 1'b0;
    case (cfuop)
      CfuBeq:  br_taken = (opr_a == opr_b);
      CfuBne:  br_taken = (opr_a != opr_b);
      CfuBlt:  br_taken = ($signed(opr_a) < $signed(opr_b));
      CfuBge:  br_taken = ($signed(opr_a) >= $signed(opr_b));
      CfuBltu: br_taken = (opr_a < opr_b);
      CfuBgeu: br_taken = (opr_a >= opr_b);
      CfuJal:  br_taken = 1'b1;
      CfuJalr: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cfu_bpu.sv
// Branch resolution plus a direct-mapped, tagged 2-bit-counter branch predictor
// with saturating performance counters.
module cfu_bpu
  import cfu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  ex_valid,
  input  cfuop_t                cfuop,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target,
  output logic                  br_taken,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  br_count,
  output logic [CNT_WIDTH-1:0]  mispred_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [ADDR_WIDTH-1:0] PcStep = ADDR_WIDTH'(4);

  logic [BHT_DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [BHT_DEPTH];
  logic [TAG_W-1:0]      tag_d [BHT_DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_q [BHT_DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_d [BHT_DEPTH];
  logic [1:0]            cnt_q [BHT_DEPTH];
  logic [1:0]            cnt_d [BHT_DEPTH];
  logic [CNT_WIDTH-1:0]  br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0]  mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             cmp_taken;
  logic             ex_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[ADDR_WIDTH-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[ADDR_WIDTH-1:IDX_W+2];

  cfu_cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .cfuop   (cfuop),
    .opr_a   (opr_a),
    .opr_b   (opr_b),
    .br_taken(cmp_taken)
  );

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_taken  = !rst && valid_q[if_idx] && (tag_q[if_idx] == if_tag) && cnt_q[if_idx][1];
    pred_target = pred_taken ? tgt_q[if_idx] : if_pc + PcStep;
  end

  always_comb begin
    br_taken    = ex_valid && cmp_taken;
    mispredict  = ex_valid && ((br_taken != ex_pred_taken) ||
                               (br_taken && (ex_pred_target != ex_target)));
    redirect_pc = br_taken ? ex_target : ex_pc + PcStep;
  end

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (ex_valid && is_cond_br(cfuop)) begin
      if (br_taken) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = ex_target;
        cnt_d[ex_idx]   = ex_hit ? sat_inc(cnt_q[ex_idx]) : WT;
      end else begin
        // Miss on a not-taken branch only reseeds the counter; the entry stays as is.
        cnt_d[ex_idx]   = ex_hit ? sat_dec(cnt_q[ex_idx]) : WNT;
      end
    end else if (ex_valid && (cfuop == CfuJal)) begin
      valid_d[ex_idx] = 1'b1;
      tag_d[ex_idx]   = ex_tag;
      tgt_d[ex_idx]   = ex_target;
      cnt_d[ex_idx]   = ST;
    end
  end

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (ex_valid && is_cfi(cfuop) && (br_count_q != '1)) begin
      br_count_d = br_count_q + CNT_WIDTH'(1);
    end
    if (mispredict && (mispred_count_q != '1)) begin
      mispred_count_d = mispred_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        cnt_q[i] <= WNT;
      end
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      tgt_q           <= tgt_d;
      cnt_q           <= cnt_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_cfu_bpu.sv
// Scoreboard bench for cfu_bpu: directed scenarios plus random traffic against a table model.
module tb_cfu_bpu;
  import cfu_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDXW  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  cfuop_t      cfuop;
  logic [31:0] opr_a, opr_b, ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic        br_taken, mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  br_count, mispred_count;

  always #5 clk = ~clk;

  cfu_bpu #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BHT_DEPTH (DEPTH),
    .CNT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .cfuop         (cfuop),
    .opr_a         (opr_a),
    .opr_b         (opr_b),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .br_taken      (br_taken),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        bt;
    logic        mp;
    logic [31:0] rpc;
    int          bc;
    int          mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference predictor state
  bit          m_valid[DEPTH];
  logic [31:0] m_tag[DEPTH];
  logic [31:0] m_tgt[DEPTH];
  int          m_cnt[DEPTH];
  int          m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic outcome(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      1: return a == b;
      2: return a != b;
      3: return $signed(a) < $signed(b);
      4: return $signed(a) >= $signed(b);
      5: return a < b;
      6: return a >= b;
      7, 8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  // Drive one cycle, push its expected response, advance the model, return at negedge+1.
  task automatic step(input logic r, input logic [31:0] ipc, input int op,
                      input logic [31:0] a, input logic [31:0] b, input logic ev,
                      input logic [31:0] epc, input logic [31:0] etgt,
                      input logic ept, input logic [31:0] eptgt);
    exp_t e;
    int   fi, xi;
    logic [31:0] ftag, xtag;
    bit   hit;
    @(posedge clk);
    #1;
    rst = r; if_pc = ipc; cfuop = cfuop_t'(op[3:0]); opr_a = a; opr_b = b;
    ex_valid = ev; ex_pc = epc; ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
    fi   = int'((ipc >> 2) % DEPTH);
    ftag = ipc >> (IDXW + 2);
    xi   = int'((epc >> 2) % DEPTH);
    xtag = epc >> (IDXW + 2);
    e.pt   = !r && m_valid[fi] && (m_tag[fi] == ftag) && (m_cnt[fi] >= 2);
    e.ptgt = e.pt ? m_tgt[fi] : ipc + 32'd4;
    e.bt   = ev && outcome(op, a, b);
    e.mp   = ev && ((e.bt != ept) || (e.bt && (eptgt != etgt)));
    e.rpc  = e.bt ? etgt : epc + 32'd4;
    e.bc   = m_bc;
    e.mc   = m_mc;
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      if (ev && op >= 1 && op <= 8 && m_bc < 15) m_bc++;
      if (e.mp && m_mc < 15) m_mc++;
      hit = m_valid[xi] && (m_tag[xi] == xtag);
      if (ev && op >= 1 && op <= 6) begin
        if (e.bt) begin
          m_cnt[xi]   = hit ? ((m_cnt[xi] == 3) ? 3 : m_cnt[xi] + 1) : 2;
          m_valid[xi] = 1;
          m_tag[xi]   = xtag;
          m_tgt[xi]   = etgt;
        end else begin
          m_cnt[xi] = hit ? ((m_cnt[xi] == 0) ? 0 : m_cnt[xi] - 1) : 1;
        end
      end else if (ev && op == 7) begin
        m_valid[xi] = 1;
        m_tag[xi]   = xtag;
        m_tgt[xi]   = etgt;
        m_cnt[xi]   = 3;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b0, ipc, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  // Monitor: outputs are always presented, one scoreboard entry per driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
        chk("pred_target", pred_target, e.ptgt);
        chk("br_taken", {31'd0, br_taken}, {31'd0, e.bt});
        chk("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("br_count", {28'd0, br_count}, e.bc[31:0]);
        chk("mispred_count", {28'd0, mispred_count}, e.mc[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] ops[6];
    logic [31:0] a, b, ipc, epc, etgt, eptgt;
    int          op;
    logic        ept, ev, r;
    ops[0] = 32'h0; ops[1] = 32'h1; ops[2] = 32'hFFFF_FFFF;
    ops[3] = 32'h8000_0000; ops[4] = 32'h7FFF_FFFF; ops[5] = 32'h5;

    rst = 1'b1; if_pc = '0; ex_valid = 1'b0; cfuop = CfuNone; opr_a = '0; opr_b = '0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    step(1'b1, 32'h100, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);

    // Post-reset lookup
    idle(32'h100);
    chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h104);

    // Signed vs unsigned compare on the same operands
    step(1'b0, 32'h0, 5, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h800, 32'h900, 1'b0, 0);
    chk("bltu_not_taken", {31'd0, br_taken}, 32'd0);
    step(1'b0, 32'h0, 3, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h800, 32'h900, 1'b1, 32'h900);
    chk("blt_taken", {31'd0, br_taken}, 32'd1);

    // Taken BEQ trains the entry; the second sees it predicted
    step(1'b0, 32'h0, 1, 32'h7, 32'h7, 1'b1, 32'h100, 32'h200, 1'b0, 0);
    chk("beq_mispredict", {31'd0, mispredict}, 32'd1);
    chk("beq_redirect", redirect_pc, 32'h200);
    step(1'b0, 32'h100, 1, 32'h7, 32'h7, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
    chk("beq_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("beq_pred_target", pred_target, 32'h200);

    // JAL sets strongly taken; three not-taken updates drop it below threshold
    step(1'b0, 32'h0, 7, 0, 0, 1'b1, 32'h40, 32'h80, 1'b0, 0);
    idle(32'h40);
    chk("jal_pred_taken", {31'd0, pred_taken}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 2, 32'h3, 32'h3, 1'b1, 32'h40, 32'h80, 1'b1, 32'h80);
    idle(32'h40);
    chk("jal_decayed", {31'd0, pred_taken}, 32'd0);

    // Same-index lookup and update: old value now, new value next cycle
    step(1'b0, 32'h14, 1, 32'h1, 32'h1, 1'b1, 32'h14, 32'h300, 1'b0, 0);
    chk("same_cycle_old", {31'd0, pred_taken}, 32'd0);
    idle(32'h14);
    chk("next_cycle_new", {31'd0, pred_taken}, 32'd1);
    chk("next_cycle_tgt", pred_target, 32'h300);

    // Saturate both counters, then reset mid-stream with an update presented
    for (int i = 0; i < 18; i++) step(1'b0, 32'h0, 2, 32'h1, 32'h1, 1'b1, 32'h60, 32'h70, 1'b1, 32'h70);
    chk("mispred_sat", {28'd0, mispred_count}, 32'hF);
    step(1'b0, 32'h0, 2, 32'h1, 32'h1, 1'b1, 32'h60, 32'h70, 1'b1, 32'h70);
    chk("mispred_hold", {28'd0, mispred_count}, 32'hF);
    chk("br_sat", {28'd0, br_count}, 32'hF);
    step(1'b1, 32'h14, 7, 0, 0, 1'b1, 32'h100, 32'h500, 1'b0, 0);
    chk("rst_pred_gated", {31'd0, pred_taken}, 32'd0);
    idle(32'h100);
    chk("rst_br_count", {28'd0, br_count}, 32'd0);
    chk("rst_mispred_count", {28'd0, mispred_count}, 32'd0);
    chk("rst_table_cleared", {31'd0, pred_taken}, 32'd0);
    idle(32'h14);
    chk("rst_table_cleared2", {31'd0, pred_taken}, 32'd0);

    // Random traffic over a small PC space so entries alias and hit often
    for (int n = 0; n < 600; n++) begin
      r     = ($urandom_range(0, 79) == 0);
      ev    = ($urandom_range(0, 7) != 0);
      op    = int'($urandom_range(0, 10));
      a     = ops[$urandom_range(0, 5)];
      b     = ($urandom_range(0, 2) == 0) ? a : ops[$urandom_range(0, 5)];
      epc   = ($urandom_range(0, 2) << (IDXW + 2)) | ($urandom_range(0, DEPTH - 1) << 2);
      ipc   = ($urandom_range(0, 1) == 0) ? epc :
              ($urandom_range(0, 2) << (IDXW + 2)) | ($urandom_range(0, DEPTH - 1) << 2);
      etgt  = {$urandom_range(0, 3), 8'h00} | ($urandom_range(0, 63) << 2);
      ept   = 1'($urandom_range(0, 1));
      eptgt = ($urandom_range(0, 3) != 0) ? etgt : $urandom;
      step(r, ipc, op, a, b, ev, epc, etgt, ept, eptgt);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
